// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder_pkg
//  Description : Shared constants for the nibble-serial adder: FSM state
//                encoding and the width of one ripple slice.
//  Revision    : 1.0  initial release
// ============================================================================
package nibble_serial_adder_pkg;

    // Width of one ripple slice; operands are processed this many bits per cycle
    localparam int c_SLICE_W = 4;

    // FSM state enumeration (IDLE, RUN, DONE), kept as explicit-width constants
    localparam int            c_ST_W    = 2;
    localparam logic [1:0]    c_ST_IDLE = 2'd0;
    localparam logic [1:0]    c_ST_RUN  = 2'd1;
    localparam logic [1:0]    c_ST_DONE = 2'd2;

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/fulladder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder_4bit
//  Description : Four-bit ripple-carry adder slice built from single-bit full
//                adders. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module fulladder_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [c_SLICE_W-1:0] a,
    input  logic [c_SLICE_W-1:0] b,
    input  logic                 cin,
    output logic [c_SLICE_W-1:0] sum,
    output logic                 cout
);

    // Carry chain: w_c[0] is the slice carry-in, w_c[c_SLICE_W] the carry-out
    logic [c_SLICE_W:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < c_SLICE_W; gi++) begin : g_bit
            assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_c[c_SLICE_W];

endmodule : fulladder_4bit
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Adds two W-bit operands (W = 4*NIBBLES) one nibble per clock
//                through a single 4-bit ripple slice. Ready/valid handshakes
//                on both sides; the result is held until the consumer takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [c_SLICE_W*NIBBLES-1:0]   a,
    input  logic [c_SLICE_W*NIBBLES-1:0]   b,
    input  logic                           cin,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [c_SLICE_W*NIBBLES-1:0]   sum,
    output logic                           cout,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int c_W      = c_SLICE_W * NIBBLES;
    // Index needs at least one bit even for a single-nibble build
    localparam int c_IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NIBBLES - 1);

    logic [c_ST_W-1:0]     r_state;
    logic [c_W-1:0]        r_a;
    logic [c_W-1:0]        r_b;
    logic                  r_carry;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_W-1:0]        r_sum;
    logic                  r_cout;

    logic                  w_accept;
    logic                  w_run;
    logic                  w_last;
    logic [c_IDX_W+1:0]    w_base;
    logic [c_SLICE_W-1:0]  w_nib_a;
    logic [c_SLICE_W-1:0]  w_nib_b;
    logic [c_SLICE_W-1:0]  w_slice_sum;
    logic                  w_slice_cout;

    // Handshake and datapath selection decoded from the current state/index
    assign w_accept = (r_state == c_ST_IDLE) && in_valid;
    assign w_run    = (r_state == c_ST_RUN);
    assign w_last   = (r_idx == c_IDX_LAST);
    // Bit offset of the current nibble: idx * 4
    assign w_base   = {r_idx, 2'b00};
    assign w_nib_a  = r_a[w_base +: c_SLICE_W];
    assign w_nib_b  = r_b[w_base +: c_SLICE_W];

    // The only adder in the block: one nibble per RUN cycle
    fulladder_4bit u_slice (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Control FSM: IDLE accepts, RUN walks the nibbles, DONE waits for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (in_valid)  r_state <= c_ST_RUN;
                c_ST_RUN:  if (w_last)    r_state <= c_ST_DONE;
                c_ST_DONE: if (out_ready) r_state <= c_ST_IDLE;
                default:                  r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Operand capture; operands are only sampled while the block is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= b;
        end
    end

    // Inter-nibble carry: seeded with cin on accept, then fed back from the slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_carry <= cin;
        end else if (w_run) begin
            r_carry <= w_slice_cout;
        end
    end

    // Nibble index; returns to 0 after the last nibble so it never exceeds NIBBLES-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_run) begin
            if (w_last) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Result assembly: one nibble of sum per RUN cycle, cout on the final nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_run) begin
            r_sum[w_base +: c_SLICE_W] <= w_slice_sum;
            if (w_last) begin
                r_cout <= w_slice_cout;
            end
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule : nibble_serial_adder
`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port a, input, W bits: operand A.
REQ-005 The block SHALL have port b, input, W bits: operand B.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in for the least significant nibble.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a, b and cin are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-009 The block SHALL have port sum, output, W bits: result, registered.
REQ-010 The block SHALL have port cout, output, 1 bit: final carry-out, registered.
REQ-011 The block SHALL have port out_valid, output, 1 bit: sum and cout hold a completed result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 In IDLE with in_valid = 1, the block SHALL capture a, b and cin into internal registers, clear sum, clear the nibble index to 0, and go to RUN.
REQ-015 Each RUN cycle SHALL add nibble[idx] of captured A and B plus the carry register through one 4-bit ripple slice; on the edge it SHALL write sum[4*idx+3:4*idx], load the carry register with the slice carry-out, and increment idx.
REQ-016 On the edge that processes idx = NIBBLES-1, the block SHALL load cout with the slice carry-out and go to DONE.
REQ-017 out_valid SHALL rise exactly NIBBLES cycles after the accepting edge (4 cycles at the default).
REQ-018 In DONE, sum, cout and out_valid SHALL hold stable until out_ready = 1; on that edge the block SHALL go to IDLE.
REQ-019 Changes on a, b, cin or in_valid outside IDLE SHALL have no effect; no operand is lost, because in_ready = 0 there.
REQ-020 DONE with out_ready = 1 and in_valid = 1 SHALL NOT accept new operands in that cycle; acceptance occurs in the following IDLE cycle (minimum issue interval NIBBLES+2 cycles).
REQ-021 Arithmetic SHALL be unsigned modulo 2^W, with the carry out of bit W-1 reported on cout; no other overflow flag exists.
REQ-022 The nibble index SHALL be ceil(log2(NIBBLES)) bits wide (minimum 1) and SHALL never exceed NIBBLES-1.

Reset
REQ-023 While rst_n = 0, the block SHALL set state to IDLE, set sum, cout, out_valid, the captured operands, the carry register and idx to 0, and drive in_ready = 1 once reset is released.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation immediately; the partial result SHALL never appear with out_valid = 1.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the slice-width constant 4.
REQ-026 The 4-bit ripple slice SHALL be the existing sub-module fulladder_4bit, instantiated once; the block SHALL contain no other adder.
REQ-027 FSM, index counter, operand and carry registers SHALL be in nibble_serial_adder itself, with no further sub-modules.

Verification
REQ-028 The bench SHALL check: a = 0xFFFF, b = 0x0001, cin = 0 -> sum = 0x0000, cout = 1, with out_valid high exactly 4 cycles after accept.
REQ-029 The bench SHALL check: a = 0x1234, b = 0x4321, cin = 1 -> sum = 0x5556, cout = 0.
REQ-030 The bench SHALL check: a = 0x00F0, b = 0x0010, cin = 0, out_ready held low 3 cycles in DONE -> sum = 0x0100 stable, out_valid high throughout, IDLE one edge after out_ready rises.
REQ-031 The bench SHALL check: a and b changed to 0xAAAA every RUN cycle after accepting 0x0003 + 0x0004 -> sum = 0x0007, cout = 0.
REQ-032 The bench SHALL check: rst_n pulsed low during RUN (idx = 2) -> out_valid = 0, sum = 0, in_ready = 1 after release; a subsequent 0x0001 + 0x0001 yields 0x0002.
REQ-033 The bench SHALL check: in_valid held high with out_ready = 1 for two operations -> second accept exactly 6 cycles after the first, with both results correct.
